uart_rx_os: RTL and testbench

Parametrised UART receiver with oversampled start-bit qualification, mid-bit sampling, configurable frame format (5–9 data bits, none/odd/even parity, 1–2 stop bits) and per-frame error flags. It sits between the board UART input pin and fabric logic. Received words are presented on a valid/ready interface, and a hardware RTS# output throttles the sender while the single-entry holding register is full.

---
 rtl/uart_rx_os.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// UART receiver: synchronised rxd, start-bit qualification at mid-bit, mid-bit data sampling,
// 5..9 data bits, optional odd/even parity, 1..2 stop bits, single-entry holding register with RTS#.
module uart_rx_os #(
    parameter int unsigned CLK_HZ      = 12_000_000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rts_n
);

    localparam int unsigned DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW  = $clog2(OVERSAMPLE);

    localparam logic [PW-1:0] DIV_LAST  = PW'(DIV - 1);
    localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SMP_HALF  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          ODD_MODE  = (PARITY == 1);

    generate
        if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 || SYNC_STAGES < 2 ||
            BAUD == 0 || DIV < 1) begin : g_bad_param
            $error("uart_rx_os: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [PW-1:0]          pre_q, pre_d;
    logic [SW-1:0]          smp_q, smp_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   valid_q, valid_d;
    logic                   hpe_q, hpe_d;
    logic                   hfe_q, hfe_d;
    logic                   ovr_q, ovr_d;
    logic                   rts_n_q, rts_n_d;

    logic rxd_s;
    logic tick;
    logic mid_tick;
    logic bit_tick;
    logic done;
    logic ferr_now;
    logic fire;

    assign rxd_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
    end

    always_comb begin
        tick     = (pre_q == DIV_LAST);
        mid_tick = tick && (smp_q == SMP_HALF);
        bit_tick = tick && (smp_q == SMP_LAST);

        pre_d = (state_q == S_IDLE || tick) ? '0 : pre_q + 1'b1;
        if (tick) begin
            smp_d = (smp_q == SMP_LAST) ? '0 : smp_q + 1'b1;
        end else begin
            smp_d = smp_q;
        end

        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        ferr_now = ferr_q;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                smp_d = '0;
                if (!rxd_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (mid_tick) begin
                    bit_d  = '0;
                    perr_d = 1'b0;
                    ferr_d = 1'b0;
                    state_d = rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                // Error when the data+parity ones-count parity disagrees with the mode.
                if (bit_tick) begin
                    perr_d  = (^shift_q) ^ rxd_s ^ ODD_MODE;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    ferr_now = ferr_q | ~rxd_s;
                    ferr_d   = ferr_now;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        done    = 1'b1;
                        state_d = ferr_now ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            smp_d = '0;
        end
    end

    always_comb begin
        fire    = valid_q && rx_ready;
        valid_d = valid_q;
        hold_d  = hold_q;
        hpe_d   = hpe_q;
        hfe_d   = hfe_q;
        ovr_d   = 1'b0;

        if (done) begin
            if (!valid_q || fire) begin
                valid_d = 1'b1;
                hold_d  = shift_q;
                hpe_d   = perr_q;
                hfe_d   = ferr_now;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (fire) begin
            valid_d = 1'b0;
        end

        // Registered from the next-state so RTS# lines up with rx_valid every cycle.
        rts_n_d = valid_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            sync_q  <= '1;
            pre_q   <= '0;
            smp_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            hpe_q   <= 1'b0;
            hfe_q   <= 1'b0;
            ovr_q   <= 1'b0;
            rts_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            pre_q   <= pre_d;
            smp_q   <= smp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            hpe_q   <= hpe_d;
            hfe_q   <= hfe_d;
            ovr_q   <= ovr_d;
            rts_n_q <= rts_n_d;
        end
    end

    assign rx_data    = hold_q;
    assign rx_valid   = valid_q;
    assign parity_err = hpe_q;
    assign frame_err  = hfe_q;
    assign overrun    = ovr_q;
    assign rts_n      = rts_n_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 and a 7E1 receiver, frame-level reference model with
// completion times derived from the sampling rules, plus directed literal checks.
module tb_uart_rx_os;

    localparam int OS   = 16;
    localparam int SYNC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       rxd_a, rxd_b, rdy_a, rdy_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       val_a, val_b, pe_a, pe_b, fe_a, fe_b, ov_a, ov_b, rts_a, rts_b;

    uart_rx_os #(
        .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(3)
    ) dut_a (
        .clk(clk), .resetn(resetn), .rxd(rxd_a), .rx_data(data_a), .rx_valid(val_a),
        .rx_ready(rdy_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a), .rts_n(rts_a)
    );

    uart_rx_os #(
        .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(3)
    ) dut_b (
        .clk(clk), .resetn(resetn), .rxd(rxd_b), .rx_data(data_b), .rx_valid(val_b),
        .rx_ready(rdy_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b), .rts_n(rts_b)
    );

    typedef struct {
        int due;
        int data;
        bit pe;
        bit fe;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    bit   m_val[2];
    int   m_data[2];
    bit   m_pe[2];
    bit   m_fe[2];

    int   cyc = 0;
    bit   re[2];
    bit   skip = 1'b1;
    bit   rnd_on;
    int   n_cmp = 0;
    int   n_bad = 0;

    int   vcnt[2], ocnt[2], last_rise[2], last_data[2];
    bit   last_pe[2], last_fe[2], pv[2];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        re[0] <= rdy_a;
        re[1] <= rdy_b;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, act, exp);
        end
    endtask

    // Frame-level model: a completed frame appears at its due cycle; holding-register rules apply.
    task automatic step(input int k, input logic v, input logic [8:0] d, input logic pe,
                        input logic fe, input logic ov, input logic rn);
        exp_t  e;
        bit    done, fire, eov;
        string p;
        p    = (k == 0) ? "a." : "b.";
        done = 1'b0;
        eov  = 1'b0;
        fire = m_val[k] && re[k];
        if (k == 0 && qa.size() > 0 && qa[0].due == cyc) begin
            e = qa.pop_front();
            done = 1'b1;
        end
        if (k == 1 && qb.size() > 0 && qb[0].due == cyc) begin
            e = qb.pop_front();
            done = 1'b1;
        end
        if (done) begin
            if (!m_val[k] || fire) begin
                m_val[k]  = 1'b1;
                m_data[k] = e.data;
                m_pe[k]   = e.pe;
                m_fe[k]   = e.fe;
            end else begin
                eov = 1'b1;
            end
        end else if (fire) begin
            m_val[k] = 1'b0;
        end
        check({p, "rx_valid"}, int'(v), int'(m_val[k]));
        check({p, "rts_n"}, int'(rn), int'(m_val[k]));
        check({p, "overrun"}, int'(ov), int'(eov));
        if (m_val[k]) begin
            check({p, "rx_data"}, int'(d), m_data[k]);
            check({p, "parity_err"}, int'(pe), int'(m_pe[k]));
            check({p, "frame_err"}, int'(fe), int'(m_fe[k]));
        end
    endtask

    always @(negedge clk) begin
        if (!skip) begin
            step(0, val_a, {1'b0, data_a}, pe_a, fe_a, ov_a, rts_a);
            step(1, val_b, {2'b0, data_b}, pe_b, fe_b, ov_b, rts_b);
        end
    end

    always @(negedge clk) begin
        if (val_a && !pv[0]) begin
            last_rise[0] = cyc; last_data[0] = int'(data_a);
            last_pe[0] = pe_a; last_fe[0] = fe_a;
        end
        if (val_b && !pv[1]) begin
            last_rise[1] = cyc; last_data[1] = int'(data_b);
            last_pe[1] = pe_b; last_fe[1] = fe_b;
        end
        vcnt[0] += int'(val_a); vcnt[1] += int'(val_b);
        ocnt[0] += int'(ov_a);  ocnt[1] += int'(ov_b);
        pv[0] = val_a; pv[1] = val_b;
    end

    task automatic clr_mon();
        vcnt[0] = 0; vcnt[1] = 0; ocnt[0] = 0; ocnt[1] = 0;
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int k, input logic v);
        if (k == 0) rxd_a = v;
        else        rxd_b = v;
    endtask

    // Called #1 after a posedge; returns at the same phase once the frame has been driven.
    task automatic send_frame(input int k, input int d, input int pbit, input int stopv,
                              input int low_extra, output int c0);
        int   nd, np, nb, ones;
        logic bits[12];
        exp_t e;
        nd = (k == 0) ? 8 : 7;
        np = (k == 0) ? 0 : 1;
        bits[0] = 1'b0;
        for (int i = 0; i < nd; i++) bits[1 + i] = ((d >> i) & 1) != 0;
        if (np == 1) bits[1 + nd] = (pbit != 0);
        bits[1 + nd + np] = (stopv != 0);
        nb = 2 + nd + np;
        c0 = cyc;
        e.data = d & ((1 << nd) - 1);
        ones = pbit;
        for (int i = 0; i < nd; i++) ones += (e.data >> i) & 1;
        e.pe  = (np == 1) && (ones % 2 != 0);
        e.fe  = (stopv == 0);
        // Detect SYNC+1 clks after the edge, start sample OS/2 ticks later, then OS per bit.
        e.due = c0 + SYNC + 1 + OS / 2 + OS * (nb - 1);
        if (k == 0) qa.push_back(e);
        else        qb.push_back(e);
        for (int b = 0; b < nb; b++) begin
            drive(k, bits[b]);
            repeat (OS) @(posedge clk);
            #1;
        end
        if (stopv == 0) idle(low_extra);
        drive(k, 1'b1);
    endtask

    task automatic check_reset_vals();
        check("rst.rx_valid", int'(val_a), 0);
        check("rst.rts_n", int'(rts_a), 1);
        check("rst.rx_data", int'(data_a), 0);
        check("rst.flags", int'({pe_a, fe_a, ov_a}), 0);
        check("rst.b_outs", int'({val_b, pe_b, fe_b, ov_b, rts_b}), 1);
        check("rst.b_data", int'(data_b), 0);
    endtask

    task automatic clear_model();
        m_val[0] = 1'b0; m_val[1] = 1'b0;
        qa.delete(); qb.delete();
    endtask

    task automatic rand_stream(input int k, input int n);
        int c0, d, pb, sv, gap;
        for (int i = 0; i < n; i++) begin
            d  = int'($urandom_range(0, 511));
            pb = int'($urandom_range(0, 1));
            sv = ($urandom_range(0, 5) == 0) ? 0 : 1;
            send_frame(k, d, pb, sv, (sv == 0) ? int'($urandom_range(0, 30)) : 0, c0);
            gap = int'($urandom_range(0, 6));
            if (sv == 0 && gap < 2) gap = 2;
            idle(gap);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        resetn = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        clear_model();
        #1 resetn = 1'b0;
        #1 check_reset_vals();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1 skip = 1'b0;
        idle(5);

        // 8N1 0xA5
        clr_mon();
        send_frame(0, 'hA5, 0, 1, 0, c0);
        idle(10);
        check("a5.count", vcnt[0], 1);
        check("a5.data", last_data[0], 'hA5);
        check("a5.latency", last_rise[0] - c0, 156);
        check("a5.errs", int'({last_pe[0], last_fe[0]}), 0);
        check("a5.overrun", ocnt[0], 0);

        // Short glitch, then 0x5A
        clr_mon();
        rxd_a = 1'b0;
        idle(4);
        rxd_a = 1'b1;
        idle(30);
        check("glitch.count", vcnt[0], 0);
        send_frame(0, 'h5A, 0, 1, 0, c0);
        idle(10);
        check("5a.count", vcnt[0], 1);
        check("5a.data", last_data[0], 'h5A);

        // 7E1: 0x41 with wrong then right parity, back to back
        clr_mon();
        send_frame(1, 'h41, 1, 1, 0, c0);
        check("par1.latency", last_rise[1] - c0, 156);
        check("par1.err", int'(last_pe[1]), 1);
        check("par1.data", last_data[1], 'h41);
        send_frame(1, 'h41, 0, 1, 0, c0);
        idle(10);
        check("par0.err", int'(last_pe[1]), 0);
        check("par.count", vcnt[1], 2);

        // Bad stop, break held low, then recovery
        clr_mon();
        send_frame(0, 'h0F, 0, 0, 40, c0);
        idle(10);
        check("brk.count", vcnt[0], 1);
        check("brk.ferr", int'(last_fe[0]), 1);
        check("brk.data", last_data[0], 'h0F);
        send_frame(0, 'h33, 0, 1, 0, c0);
        idle(10);
        check("33.data", last_data[0], 'h33);
        check("33.ferr", int'(last_fe[0]), 0);
        check("33.count", vcnt[0], 2);

        // Overrun with consumer stalled
        clr_mon();
        rdy_a = 1'b0;
        send_frame(0, 'h11, 0, 1, 0, c0);
        send_frame(0, 'h22, 0, 1, 0, c0);
        idle(5);
        check("ovr.data", int'(data_a), 'h11);
        check("ovr.rts_n", int'(rts_a), 1);
        check("ovr.pulses", ocnt[0], 1);
        rdy_a = 1'b1;
        @(posedge clk); #1 rdy_a = 1'b0;
        check("ovr.drain_valid", int'(val_a), 0);
        check("ovr.drain_rts", int'(rts_a), 0);
        idle(3);
        rdy_a = 1'b1;

        // Reset during data bit 3
        rxd_a = 1'b0; idle(OS);
        rxd_a = 1'b1; idle(OS);
        rxd_a = 1'b0; idle(OS);
        rxd_a = 1'b1; idle(OS);
        rxd_a = 1'b0; idle(8);
        #3 skip = 1'b1;
        resetn = 1'b0;
        #1 check_reset_vals();
        rxd_a = 1'b1;
        clear_model();
        @(posedge clk); #1;
        idle(2);
        resetn = 1'b1;
        @(posedge clk); #1 skip = 1'b0;
        clr_mon();
        send_frame(0, 'h3C, 0, 1, 0, c0);
        idle(10);
        check("3c.data", last_data[0], 'h3C);
        check("3c.errs", int'({last_pe[0], last_fe[0]}), 0);

        // Randomised traffic on both receivers with a sparse consumer
        rnd_on = 1'b1;
        fork
            begin
                fork
                    rand_stream(0, 25);
                    rand_stream(1, 25);
                join
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    rdy_a = ($urandom_range(0, 19) == 0);
                    rdy_b = ($urandom_range(0, 19) == 0);
                end
            end
        join
        rdy_a = 1'b1; rdy_b = 1'b1;
        idle(50);
        check("a.queue_drained", qa.size(), 0);
        check("b.queue_drained", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
